instr_class_counter: RTL and testbench

// - Consumes per-instruction class strobes (r, i, j) from the opcode classifier and accumulates run statistics.
// - Keeps cycle, retired R/I/J/other counts, a halt state machine and a registered readout port.
// - Sits beside the single-cycle CPU datapath; readout feeds the board display / test bench.

---
 rtl/instr_class_counter_pkg.sv | 31 +++
 rtl/instr_class_counter_stat_cnt.sv | 54 +++++
 rtl/instr_class_counter.sv | 120 ++++++++++++
 tb/tb_instr_class_counter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_class_counter_pkg.sv
// Shared definitions for instr_class_counter: readout select codes, counter
// indices, status word bit positions and the run/halt state type.
package instr_class_counter_pkg;

    localparam logic [2:0] SEL_CYCLES = 3'd0;
    localparam logic [2:0] SEL_TOTAL  = 3'd1;
    localparam logic [2:0] SEL_R      = 3'd2;
    localparam logic [2:0] SEL_I      = 3'd3;
    localparam logic [2:0] SEL_J      = 3'd4;
    localparam logic [2:0] SEL_OTHER  = 3'd5;
    localparam logic [2:0] SEL_STATUS = 3'd6;
    localparam logic [2:0] SEL_ZERO   = 3'd7;

    localparam int NUM_CNT = 6;
    localparam int CNT_CYC = 0;
    localparam int CNT_TOT = 1;
    localparam int CNT_R   = 2;
    localparam int CNT_I   = 3;
    localparam int CNT_J   = 4;
    localparam int CNT_OTH = 5;

    localparam int ST_HALTED = 0;
    localparam int ST_ERR    = 1;
    localparam int ST_WRAP   = 2;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/instr_class_counter_stat_cnt.sv
// One statistics counter with clear/increment/freeze and a sticky overflow flag.
// STAT_SATURATE_EN: hold at all-ones and flag on reaching it; otherwise wrap and flag on wrap.
module stat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             freeze,
    output logic [CNT_W-1:0] cnt,
    output logic             flag
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_d;
    logic             flag_d;

    // Clear wins over freeze, freeze wins over increment.
    always_comb begin
        cnt_d  = cnt;
        flag_d = flag;
        if (clr) begin
            cnt_d  = '0;
            flag_d = 1'b0;
        end else if (inc && !freeze) begin
`ifdef STAT_SATURATE_EN
            if (cnt != CNT_MAX) begin
                cnt_d = cnt + 1'b1;
            end
            if (cnt_d == CNT_MAX) begin
                flag_d = 1'b1;
            end
`else
            cnt_d = cnt + 1'b1;
            if (cnt == CNT_MAX) begin
                flag_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            flag <= flag_d;
        end
    end

endmodule

// File: rtl/instr_class_counter.sv
// Instruction class statistics: cycle/total/R/I/J/other counters, run/halt FSM,
// sticky multi-strobe error and registered readout. Option: STAT_SATURATE_EN.
module instr_class_counter
    import instr_class_counter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             retire,
    input  logic             r,
    input  logic             i,
    input  logic             j,
    input  logic             halt,
    input  logic             clear,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             halted,
    output logic             err,
    output state_t           state_dbg
);

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [NUM_CNT-1:0] inc;
    logic [NUM_CNT-1:0] flag;
    logic             freeze;
    logic             run;
    logic             multi;
    logic [CNT_W-1:0] rd_d;

    assign run       = (state_q == RUN);
    assign freeze    = !run;
    assign halted    = (state_q == HALTED);
    assign state_dbg = state_q;

    // Strobe contract: retire qualifies r/i/j in the same cycle; with retire
    // low the strobes are don't-care, and there is no backpressure.
    assign multi = (r & i) | (r & j) | (i & j);

    always_comb begin
        inc          = '0;
        inc[CNT_CYC] = 1'b1;
        inc[CNT_TOT] = retire;
        inc[CNT_R]   = retire & r & ~multi;
        inc[CNT_I]   = retire & i & ~multi;
        inc[CNT_J]   = retire & j & ~multi;
        inc[CNT_OTH] = retire & ~(r | i | j);
    end

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        stat_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clear),
            .inc   (inc[k]),
            .freeze(freeze),
            .cnt   (cnt_q[k]),
            .flag  (flag[k])
        );
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = RUN;
        end else if (state_q == RUN && halt) begin
            state_d = HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Only a retire seen while running can raise the error; halted cycles are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (clear) begin
            err <= 1'b0;
        end else if (run && retire && multi) begin
            err <= 1'b1;
        end
    end

    always_comb begin
        rd_d = '0;
        case (rd_sel)
            SEL_CYCLES: rd_d = cnt_q[CNT_CYC];
            SEL_TOTAL:  rd_d = cnt_q[CNT_TOT];
            SEL_R:      rd_d = cnt_q[CNT_R];
            SEL_I:      rd_d = cnt_q[CNT_I];
            SEL_J:      rd_d = cnt_q[CNT_J];
            SEL_OTHER:  rd_d = cnt_q[CNT_OTH];
            SEL_STATUS: begin
                rd_d[ST_HALTED] = halted;
                rd_d[ST_ERR]    = err;
                rd_d[ST_WRAP]   = |flag;
            end
            default:    rd_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_d;
        end
    end

endmodule

// File: tb/tb_instr_class_counter.sv
// Bench for instr_class_counter: an 8-bit and a 4-bit instance share stimulus
// and are checked every cycle against a count-based model, plus literal reads.
module tb_instr_class_counter;
    import instr_class_counter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n  = 1'b0;
    logic       retire = 1'b0;
    logic       r = 1'b0, i = 1'b0, j = 1'b0;
    logic       halt = 1'b0, clear = 1'b0;
    logic [2:0] rd_sel = 3'd0;

    logic [7:0] rd8;
    logic [3:0] rd4;
    logic       halted8, err8, halted4, err4;
    state_t     st8, st4;

    instr_class_counter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .retire(retire), .r(r), .i(i), .j(j),
        .halt(halt), .clear(clear), .rd_sel(rd_sel), .rd_data(rd8),
        .halted(halted8), .err(err8), .state_dbg(st8)
    );

    instr_class_counter #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .retire(retire), .r(r), .i(i), .j(j),
        .halt(halt), .clear(clear), .rd_sel(rd_sel), .rd_data(rd4),
        .halted(halted4), .err(err4), .state_dbg(st4)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;
    bit done     = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // True event counts since clear/reset; the visible value per width is derived.
    longint     m_cnt [6];
    bit         m_halted = 1'b0;
    bit         m_err    = 1'b0;
    logic [7:0] exp_q[$];
    logic [3:0] exp4 = 4'h0;
    bit         exp_halted = 1'b0;
    bit         exp_err    = 1'b0;

    function automatic logic [31:0] view(longint c, int w);
        longint m = longint'(1) << w;
`ifdef STAT_SATURATE_EN
        return (c >= m - 1) ? 32'(m - 1) : 32'(c);
`else
        return 32'(c % m);
`endif
    endfunction

    function automatic bit hit(longint c, int w);
        longint m = longint'(1) << w;
`ifdef STAT_SATURATE_EN
        return c >= m - 1;
`else
        return c >= m;
`endif
    endfunction

    function automatic logic [31:0] sel_val(int sel, int w);
        bit any = 1'b0;
        for (int k = 0; k < 6; k++) any |= hit(m_cnt[k], w);
        if (sel < 6) return view(m_cnt[sel], w);
        if (sel == 6) return {29'd0, any, m_err, m_halted};
        return 32'd0;
    endfunction

    initial begin
        logic [31:0] e8, e4;
        int nstrobe;
        for (int k = 0; k < 6; k++) m_cnt[k] = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                e8 = 32'd0;
                e4 = 32'd0;
            end else begin
                e8 = sel_val(int'(rd_sel), 8);
                e4 = sel_val(int'(rd_sel), 4);
            end
            exp_q.push_back(e8[7:0]);
            exp4 = e4[3:0];
            if (!rst_n || clear) begin
                for (int k = 0; k < 6; k++) m_cnt[k] = 0;
                m_halted = 1'b0;
                m_err    = 1'b0;
            end else if (!m_halted) begin
                m_cnt[0]++;
                if (retire) begin
                    m_cnt[1]++;
                    nstrobe = int'(r) + int'(i) + int'(j);
                    if (nstrobe > 1) m_err = 1'b1;
                    else if (r) m_cnt[2]++;
                    else if (i) m_cnt[3]++;
                    else if (j) m_cnt[4]++;
                    else m_cnt[5]++;
                end
                if (halt) m_halted = 1'b1;
            end
            exp_halted = m_halted;
            exp_err    = m_err;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!done && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_data_w8", 32'(rd8), 32'(e));
                check("rd_data_w4", 32'(rd4), 32'(exp4));
                check("halted_w8", 32'(halted8), 32'(exp_halted));
                check("err_w8", 32'(err8), 32'(exp_err));
                check("halted_w4", 32'(halted4), 32'(exp_halted));
                check("err_w4", 32'(err4), 32'(exp_err));
                check("state_dbg_w8", 32'(st8 == HALTED), 32'(exp_halted));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit rt, input bit rr, input bit ii, input bit jj,
                         input bit hh, input bit cc);
        retire = rt; r = rr; i = ii; j = jj; halt = hh; clear = cc;
        @(posedge clk);
        @(negedge clk);
        retire = 1'b0; r = 1'b0; i = 1'b0; j = 1'b0; halt = 1'b0; clear = 1'b0;
    endtask

    task automatic read_check(input logic [2:0] sel, input logic [7:0] exp, input string name);
        rd_sel = sel;
        @(posedge clk);
        @(negedge clk);
        check(name, 32'(rd8), 32'(exp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        @(posedge clk);
        @(negedge clk);
        check("reset_rd_data", 32'(rd8), 32'd0);
        check("reset_halted", 32'(halted8), 32'd0);
        check("reset_err", 32'(err8), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (10) drive(0, 0, 0, 0, 0, 0);
        read_check(SEL_CYCLES, 8'd10, "idle_cycles");
        read_check(SEL_TOTAL, 8'd0, "idle_total");
        read_check(SEL_R, 8'd0, "idle_r");
        read_check(SEL_I, 8'd0, "idle_i");
        read_check(SEL_J, 8'd0, "idle_j");
        read_check(SEL_OTHER, 8'd0, "idle_other");

        repeat (3) drive(1, 1, 0, 0, 0, 0);
        repeat (2) drive(1, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0);
        read_check(SEL_R, 8'd3, "mix_r");
        read_check(SEL_I, 8'd2, "mix_i");
        read_check(SEL_J, 8'd1, "mix_j");
        read_check(SEL_OTHER, 8'd1, "mix_other");
        read_check(SEL_TOTAL, 8'd7, "mix_total");
        read_check(SEL_STATUS, 8'h0, "mix_status");

        drive(1, 1, 1, 0, 0, 0);
        read_check(SEL_STATUS, 8'h2, "multi_status");
        read_check(SEL_TOTAL, 8'd8, "multi_total");
        read_check(SEL_R, 8'd3, "multi_r");
        read_check(SEL_I, 8'd2, "multi_i");

        drive(1, 0, 1, 0, 1, 0);
        repeat (5) drive(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
        read_check(SEL_I, 8'd3, "halt_i");
        read_check(SEL_TOTAL, 8'd9, "halt_total");
        read_check(SEL_STATUS, 8'h3, "halt_status");
        check("halt_halted", 32'(halted8), 32'd1);

        drive(1, 1, 0, 0, 0, 1);
        check("clear_halted", 32'(halted8), 32'd0);
        check("clear_err", 32'(err8), 32'd0);
        read_check(SEL_R, 8'd0, "clear_r");
        read_check(SEL_TOTAL, 8'd0, "clear_total");

        drive(0, 0, 0, 0, 0, 1);
        repeat (16) drive(1, 1, 0, 0, 0, 0);
        read_check(SEL_R, 8'd16, "r16_w8");
`ifdef STAT_SATURATE_EN
        check("r16_w4", 32'(rd4), 32'd15);
`else
        check("r16_w4", 32'(rd4), 32'd0);
`endif
        read_check(SEL_STATUS, 8'h0, "r16_status_w8");
        check("r16_status_w4_bit2", 32'(rd4[2]), 32'd1);

        // Long run without clear: exercises wrap/saturation of the 8-bit counters.
        drive(0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 700; n++) begin
            rd_sel = 3'($urandom_range(0, 7));
            k = $urandom_range(0, 99);
            if (k < 2) drive(1, 1, 0, 1, 0, 0);
            else if (k < 62) drive(1, 1, 0, 0, 0, 0);
            else if (k < 72) drive(1, 0, 1, 0, 0, 0);
            else if (k < 80) drive(1, 0, 0, 1, 0, 0);
            else if (k < 88) drive(1, 0, 0, 0, 0, 0);
            else drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 0, 0);
        end

        // Mixed traffic with halts, clears and occasional resets.
        for (int n = 0; n < 2500; n++) begin
            rd_sel = 3'($urandom_range(0, 7));
            rst_n  = ($urandom_range(0, 499) != 0);
            drive(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 99) == 0), ($urandom_range(0, 59) == 0));
            rst_n = 1'b1;
        end

        drive(0, 0, 0, 0, 0, 0);
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
